// File: rtl/axis_width_downsizer_if.sv
// AXI-Stream bundle (valid/ready/data/last) of parameterised data width.
// The master modport drives a stream and the slave modport receives one.
interface axis_width_downsizer_if #(
  parameter int W = 8
) ();
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_width_downsizer.sv
// Splits each wide AXIS word into IN_WIDTH/OUT_WIDTH narrow beats, LSB slice first, one register stage.
// Upstream ready is only offered when empty or when the final beat is leaving, so words stream with no bubbles.
module axis_width_downsizer #(
  parameter int IN_WIDTH  = 512,
  parameter int OUT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  axis_width_downsizer_if.slave   s_axis,
  axis_width_downsizer_if.master  m_axis
);
  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_params
    $error("axis_width_downsizer: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
  end

  typedef enum logic {EMPTY = 1'b0, BUSY = 1'b1} state_t;

  state_t                             state;
  logic [RATIO-1:0][OUT_WIDTH-1:0]    holding;
  logic                               stored_tlast;
  logic [IDX_W-1:0]                   idx;

  logic full;
  logic last_beat;
  logic s_hs;
  logic m_hs;

  assign full      = (state == BUSY);
  assign last_beat = (idx == LAST_IDX);

  // Ready passes through combinationally on the final beat so the next word loads with no gap.
  assign s_axis.tready = ~full | (m_axis.tready & last_beat);
  assign s_hs          = s_axis.tvalid & s_axis.tready;
  assign m_hs          = full & m_axis.tready;

  assign m_axis.tvalid = full;
  assign m_axis.tdata  = holding[idx];
  assign m_axis.tlast  = full & stored_tlast & last_beat;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= EMPTY;
      holding      <= '0;
      stored_tlast <= 1'b0;
      idx          <= '0;
    end else if (s_hs) begin
      // A new word wins over clearing on a simultaneous final beat.
      state        <= BUSY;
      holding      <= s_axis.tdata;
      stored_tlast <= s_axis.tlast;
      idx          <= '0;
    end else if (m_hs) begin
      if (last_beat) begin
        state <= EMPTY;
        idx   <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end
endmodule
